// File: rtl/tdm_demux_1to16.sv
// tdm_demux_1to16
//   Receive side of a 16-slot TDM link. Words arrive one per valid cycle. The
//   block aligns on start-of-frame and steers each word into a 16-entry shadow
//   buffer. When the slot-15 word is accepted, all 16 channel outputs are
//   loaded together on the next cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_data      W-bit TDM word for the current slot
//   in_valid     in_data valid this cycle
//   sof          start of frame (qualified by in_valid), marks the slot-0 word
//   out0..out15  registered channel words of the last complete frame
//   frame_valid  1-cycle pulse when out0..out15 have just been updated
//   slot         slot index that the next accepted word will fill
//   err_sof      1-cycle pulse when sof cut short an incomplete frame
//
// State | Meaning
// IDLE  | hunting for sof; words without sof are dropped
// RUN   | collecting slots 1..15 of the current frame
module tdm_demux_1to16 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         sof,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] out4,
  output logic [W-1:0] out5,
  output logic [W-1:0] out6,
  output logic [W-1:0] out7,
  output logic [W-1:0] out8,
  output logic [W-1:0] out9,
  output logic [W-1:0] out10,
  output logic [W-1:0] out11,
  output logic [W-1:0] out12,
  output logic [W-1:0] out13,
  output logic [W-1:0] out14,
  output logic [W-1:0] out15,
  output logic         frame_valid,
  output logic [3:0]   slot,
  output logic         err_sof
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [3:0]   slot_q, slot_d;
  logic [W-1:0] shadow [16];
  logic [W-1:0] out_q  [16];
  logic         wr_en;
  logic [3:0]   wr_idx;
  logic         complete;
  logic         abort;
  logic         fv_q;
  logic         err_q;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_en    = 1'b0;
    wr_idx   = slot_q;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && sof) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          slot_d  = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (sof) begin
            // Restart: the partial frame is simply overwritten from slot 0.
            abort  = 1'b1;
            wr_en  = 1'b1;
            wr_idx = 4'd0;
            slot_d = 4'd1;
          end else if (slot_q == 4'd15) begin
            // Slot 15 bypasses the shadow and goes straight to out_q.
            complete = 1'b1;
            slot_d   = 4'd0;
            state_d  = IDLE;
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 4'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) out_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= complete;
      err_q   <= abort;
      if (complete) begin
        for (int i = 0; i < 15; i++) out_q[i] <= shadow[i];
        out_q[15] <= in_data;
      end
    end
  end

  // Shadow contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (wr_en) shadow[wr_idx] <= in_data;
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign out4        = out_q[4];
  assign out5        = out_q[5];
  assign out6        = out_q[6];
  assign out7        = out_q[7];
  assign out8        = out_q[8];
  assign out9        = out_q[9];
  assign out10       = out_q[10];
  assign out11       = out_q[11];
  assign out12       = out_q[12];
  assign out13       = out_q[13];
  assign out14       = out_q[14];
  assign out15       = out_q[15];
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign err_sof     = err_q;

endmodule

// File: tb/tb_tdm_demux_1to16.sv
module tb_tdm_demux_1to16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] dut_out [16];
  logic       frame_valid;
  logic [3:0] slot;
  logic       err_sof;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux_1to16 #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sof(sof),
    .out0(dut_out[0]), .out1(dut_out[1]), .out2(dut_out[2]), .out3(dut_out[3]),
    .out4(dut_out[4]), .out5(dut_out[5]), .out6(dut_out[6]), .out7(dut_out[7]),
    .out8(dut_out[8]), .out9(dut_out[9]), .out10(dut_out[10]), .out11(dut_out[11]),
    .out12(dut_out[12]), .out13(dut_out[13]), .out14(dut_out[14]), .out15(dut_out[15]),
    .frame_valid(frame_valid), .slot(slot), .err_sof(err_sof)
  );

  // Reference model: a frame is a list of words that starts with sof and is
  // published once it holds 16 entries.
  bit         m_in_frame = 1'b0;
  logic [7:0] m_buf [$];
  logic [7:0] m_out [16];
  bit         m_fv = 1'b0;
  bit         m_err = 1'b0;

  function automatic void model(input logic r, input logic v, input logic s, input logic [7:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_in_frame = 1'b0;
      m_buf.delete();
      for (int i = 0; i < 16; i++) m_out[i] = 8'h00;
    end else if (v) begin
      if (s) begin
        m_err = m_in_frame;
        m_buf.delete();
        m_buf.push_back(d);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_buf.push_back(d);
        if (m_buf.size() == 16) begin
          for (int i = 0; i < 16; i++) m_out[i] = m_buf[i];
          m_fv = 1'b1;
          m_in_frame = 1'b0;
          m_buf.delete();
        end
      end
    end
  endfunction

  task automatic check_model();
    int exp_slot;
    exp_slot = m_buf.size();
    vec_cnt++;
    if (frame_valid !== m_fv) begin
      err_cnt++;
      $display("FAIL fv t=%0t got=%b exp=%b", $time, frame_valid, m_fv);
    end
    if (err_sof !== m_err) begin
      err_cnt++;
      $display("FAIL err_sof t=%0t got=%b exp=%b", $time, err_sof, m_err);
    end
    if (slot !== exp_slot[3:0]) begin
      err_cnt++;
      $display("FAIL slot t=%0t got=%0d exp=%0d", $time, slot, exp_slot);
    end
    for (int i = 0; i < 16; i++) begin
      if (dut_out[i] !== m_out[i]) begin
        err_cnt++;
        $display("FAIL out%0d t=%0t got=%h exp=%h", i, $time, dut_out[i], m_out[i]);
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    rst = r; in_valid = v; sof = s; in_data = d;
    @(posedge clk);
    model(r, v, s, d);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 5));
      step(1'b0, 1'b1, (k == 0), base + 8'(k));
    end
  endtask

  typedef struct {
    logic       r, v, s;
    logic [7:0] d;
    logic       fv, err;
    logic [3:0] sl;
    logic [7:0] o0, o15;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // Reset, three dropped 0xAA words, a contiguous 0x10..0x1F frame, one idle.
    tbl[0] = '{r:1, v:0, s:0, d:8'h00, fv:0, err:0, sl:0, o0:8'h00, o15:8'h00};
    for (int i = 1; i <= 3; i++)
      tbl[i] = '{r:0, v:1, s:0, d:8'hAA, fv:0, err:0, sl:0, o0:8'h00, o15:8'h00};
    for (int k = 0; k < 16; k++)
      tbl[4+k] = '{r:0, v:1, s:(k == 0), d:8'h10 + 8'(k), fv:(k == 15), err:0,
                   sl:4'(k + 1), o0:(k == 15) ? 8'h10 : 8'h00, o15:(k == 15) ? 8'h1F : 8'h00};
    tbl[20] = '{r:0, v:0, s:0, d:8'h55, fv:0, err:0, sl:0, o0:8'h10, o15:8'h1F};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      vec_cnt++;
      if (frame_valid !== tbl[i].fv || err_sof !== tbl[i].err || slot !== tbl[i].sl ||
          dut_out[0] !== tbl[i].o0 || dut_out[15] !== tbl[i].o15) begin
        err_cnt++;
        $display("FAIL tbl[%0d] got fv=%b err=%b slot=%0d o0=%h o15=%h exp fv=%b err=%b slot=%0d o0=%h o15=%h",
                 i, frame_valid, err_sof, slot, dut_out[0], dut_out[15],
                 tbl[i].fv, tbl[i].err, tbl[i].sl, tbl[i].o0, tbl[i].o15);
      end
    end

    // Frame with idle gaps between random slots.
    send_frame(8'h30, 1'b1);
    idle(2);

    // Abort after 7 words, then a full frame.
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, (k == 0), 8'h60 + 8'(k));
    send_frame(8'h20, 1'b0);
    idle(2);

    // Back-to-back frames.
    send_frame(8'h00, 1'b0);
    send_frame(8'hF0, 1'b0);
    idle(2);

    // Reset after slot 9 of the second frame, then a fresh frame.
    send_frame(8'h40, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, (k == 0), 8'h50 + 8'(k));
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    send_frame(8'h70, 1'b0);
    idle(1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 17) == 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
